// File: rtl/samay_setter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | samay_setter_pkg                                                     |
// | FSM/target encodings, BCD limits and HH:MM increment helpers.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package samay_setter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SET_HRS = 2'd1,
    ST_SET_MIN = 2'd2,
    ST_COMMIT  = 2'd3
  } state_e;

  typedef enum logic {
    TGT_TIME  = 1'b0,
    TGT_ALARM = 1'b1
  } target_e;

  localparam logic [1:0] HRS_MAX_TENS      = 2'd2;
  localparam logic [3:0] HRS_MAX_ONES_AT_2 = 4'd3;
  localparam logic [3:0] MIN_MAX_TENS      = 4'd5;
  localparam logic [3:0] DIGIT_MAX         = 4'd9;

  typedef struct packed {
    logic [1:0] hrs_tens;
    logic [3:0] hrs_ones;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
  } hhmm_t;

  // Hours wrap 23 -> 00 without touching the minutes.
  function automatic hhmm_t bcd_inc_hrs(input hhmm_t v);
    hhmm_t r;
    r = v;
    if (v.hrs_tens == HRS_MAX_TENS && v.hrs_ones == HRS_MAX_ONES_AT_2) begin
      r.hrs_tens = 2'd0;
      r.hrs_ones = 4'd0;
    end else if (v.hrs_ones == DIGIT_MAX) begin
      r.hrs_tens = v.hrs_tens + 2'd1;
      r.hrs_ones = 4'd0;
    end else begin
      r.hrs_ones = v.hrs_ones + 4'd1;
    end
    return r;
  endfunction

  function automatic hhmm_t bcd_inc_min(input hhmm_t v);
    hhmm_t r;
    r = v;
    if (v.min_ones == DIGIT_MAX) begin
      r.min_ones = 4'd0;
      r.min_tens = (v.min_tens == MIN_MAX_TENS) ? 4'd0 : v.min_tens + 4'd1;
    end else begin
      r.min_ones = v.min_ones + 4'd1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/samay_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | samay_debounce                                                       |
// | Two-flop synchroniser, stable-sample filter and rising-edge event.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module samay_debounce #(
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
`ifdef SAMAY_AUTO_REPEAT_EN
  output logic o_level,
`endif
  output logic o_event
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          event_q, event_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt counts consecutive synchronised samples that disagree with the accepted level.
  always_comb begin
    level_d = level_q;
    event_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == C_LAST) begin
        level_d = sync2_q;
        event_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      event_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
      level_q <= level_d;
      event_q <= event_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_event = event_q;
`ifdef SAMAY_AUTO_REPEAT_EN
  assign o_level = level_q;
`endif

endmodule
`default_nettype wire

// File: rtl/samay_setter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | samay_setter                                                         |
// | Button-driven HH:MM editor feeding the alarm-clock core.             |
// | Optional: SAMAY_AUTO_REPEAT_EN adds hold-to-repeat on the Up button. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module samay_setter
  import samay_setter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int TIMEOUT_CYCLES  = 100
`ifdef SAMAY_AUTO_REPEAT_EN
  , parameter int REPEAT_CYCLES = 5
`endif
) (
  input  logic       Ghadi,
  input  logic       Reset,
  input  logic       Btn_Samay,
  input  logic       Btn_Alarm,
  input  logic       Btn_Up,
  input  logic       Btn_Next,
  input  logic [1:0] Cur_Hours_Tenth,
  input  logic [3:0] Cur_Hours_Ones,
  input  logic [3:0] Cur_Mins_Tenth,
  input  logic [3:0] Cur_Mins_Ones,
  output logic [1:0] Hours_Ki_Tenth_digit_SET,
  output logic [3:0] Hours_Ki_Ones_digit_SET,
  output logic [3:0] Mins_Ki_Tenth_digit_SET,
  output logic [3:0] Mins_Ki_Ones_digit_SET,
  output logic       Load_Samay,
  output logic       Load_Alarm,
  output logic       Editing,
  output logic       Edit_Field
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] C_TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [3:0] btn_raw, btn_ev;
  logic       samay_ev, alarm_ev, up_ev, next_ev, any_ev;
  logic       edit_st, rep_fire;

  state_e        state_q, state_d;
  target_e       tgt_q, tgt_d;
  hhmm_t         set_q, set_d, alarm_q, alarm_d, cur;
  logic [TW-1:0] to_q, to_d;
  logic          editing_q, editing_d, field_q, field_d;
  logic          ld_samay_q, ld_samay_d, ld_alarm_q, ld_alarm_d;

  assign btn_raw = {Btn_Next, Btn_Up, Btn_Alarm, Btn_Samay};

`ifdef SAMAY_AUTO_REPEAT_EN
  logic [3:0] btn_lvl;
`endif

  for (genvar i = 0; i < 4; i++) begin : g_btn
    samay_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (Ghadi),
      .rst     (Reset),
      .i_btn   (btn_raw[i]),
`ifdef SAMAY_AUTO_REPEAT_EN
      .o_level (btn_lvl[i]),
`endif
      .o_event (btn_ev[i])
    );
  end

  assign samay_ev = btn_ev[0];
  assign alarm_ev = btn_ev[1];
  assign up_ev    = btn_ev[2];
  assign next_ev  = btn_ev[3];
  assign any_ev   = |btn_ev;
  assign edit_st  = (state_q == ST_SET_HRS) || (state_q == ST_SET_MIN);
  assign cur      = {Cur_Hours_Tenth, Cur_Hours_Ones, Cur_Mins_Tenth, Cur_Mins_Ones};

`ifdef SAMAY_AUTO_REPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] C_REP_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rep_q, rep_d;

  always_comb begin
    rep_d    = '0;
    rep_fire = 1'b0;
    if (edit_st && btn_lvl[2] && !up_ev && !next_ev) begin
      if (rep_q == C_REP_LAST) rep_fire = 1'b1;
      else                     rep_d    = rep_q + RW'(1);
    end
  end

  always_ff @(posedge Ghadi or posedge Reset) begin
    if (Reset) rep_q <= '0;
    else       rep_q <= rep_d;
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    set_d   = set_q;
    alarm_d = alarm_q;
    case (state_q)
      ST_IDLE: begin
        if (samay_ev) begin
          set_d   = cur;
          tgt_d   = TGT_TIME;
          state_d = ST_SET_HRS;
        end else if (alarm_ev) begin
          set_d   = alarm_q;
          tgt_d   = TGT_ALARM;
          state_d = ST_SET_HRS;
        end
      end
      ST_SET_HRS, ST_SET_MIN: begin
        if (next_ev) begin
          state_d = (state_q == ST_SET_HRS) ? ST_SET_MIN : ST_COMMIT;
        end else if (up_ev || rep_fire) begin
          set_d = (state_q == ST_SET_HRS) ? bcd_inc_hrs(set_q) : bcd_inc_min(set_q);
        end else if (!any_ev && to_q == C_TO_LAST) begin
          state_d = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        if (tgt_q == TGT_ALARM) alarm_d = set_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Idle timer restarts on any button activity or state transition.
    if (!edit_st || state_d != state_q || any_ev || rep_fire) to_d = '0;
    else                                                       to_d = to_q + TW'(1);
  end

  always_comb begin
    editing_d  = (state_d == ST_SET_HRS) || (state_d == ST_SET_MIN);
    field_d    = (state_d == ST_SET_MIN);
    ld_samay_d = (state_d == ST_COMMIT) && (tgt_d == TGT_TIME);
    ld_alarm_d = (state_d == ST_COMMIT) && (tgt_d == TGT_ALARM);
  end

  always_ff @(posedge Ghadi or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      tgt_q      <= TGT_TIME;
      set_q      <= '0;
      alarm_q    <= '0;
      to_q       <= '0;
      editing_q  <= 1'b0;
      field_q    <= 1'b0;
      ld_samay_q <= 1'b0;
      ld_alarm_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      set_q      <= set_d;
      alarm_q    <= alarm_d;
      to_q       <= to_d;
      editing_q  <= editing_d;
      field_q    <= field_d;
      ld_samay_q <= ld_samay_d;
      ld_alarm_q <= ld_alarm_d;
    end
  end

  assign Hours_Ki_Tenth_digit_SET = set_q.hrs_tens;
  assign Hours_Ki_Ones_digit_SET  = set_q.hrs_ones;
  assign Mins_Ki_Tenth_digit_SET  = set_q.min_tens;
  assign Mins_Ki_Ones_digit_SET   = set_q.min_ones;
  assign Load_Samay               = ld_samay_q;
  assign Load_Alarm               = ld_alarm_q;
  assign Editing                  = editing_q;
  assign Edit_Field               = field_q;

endmodule
`default_nettype wire

// File: tb/tb_samay_setter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_samay_setter                                                      |
// | Directed bench with a minute/hour-level model of the set-mode editor.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_samay_setter;

  localparam int TIMEOUT = 100;
  localparam logic [3:0] B_S = 4'b0001, B_A = 4'b0010, B_U = 4'b0100, B_N = 4'b1000;

  logic       Ghadi = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] btn   = 4'b0;
  logic [1:0] cht   = 2'd0;
  logic [3:0] cho = 4'd0, cmt = 4'd0, cmo = 4'd0;
  logic [1:0] sht;
  logic [3:0] sho, smt, smo;
  logic       Load_Samay, Load_Alarm, Editing, Edit_Field;

  samay_setter #(.DEBOUNCE_CYCLES(2), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .Ghadi                    (Ghadi),
    .Reset                    (Reset),
    .Btn_Samay                (btn[0]),
    .Btn_Alarm                (btn[1]),
    .Btn_Up                   (btn[2]),
    .Btn_Next                 (btn[3]),
    .Cur_Hours_Tenth          (cht),
    .Cur_Hours_Ones           (cho),
    .Cur_Mins_Tenth           (cmt),
    .Cur_Mins_Ones            (cmo),
    .Hours_Ki_Tenth_digit_SET (sht),
    .Hours_Ki_Ones_digit_SET  (sho),
    .Mins_Ki_Tenth_digit_SET  (smt),
    .Mins_Ki_Ones_digit_SET   (smo),
    .Load_Samay               (Load_Samay),
    .Load_Alarm               (Load_Alarm),
    .Editing                  (Editing),
    .Edit_Field               (Edit_Field)
  );

  always #5 Ghadi = ~Ghadi;

  int vecs = 0, errs = 0;
  // model: mode 0 idle, 1 hours, 2 minutes; times kept as plain integers
  int m_mode = 0, m_hh = 0, m_mm = 0, m_ah = 0, m_am = 0, m_idle = 0;
  int cur_h = 0, cur_m = 0;
  bit m_alarm_tgt = 0, m_ls = 0, m_la = 0;
  int n_ls = 0, n_la = 0;
  logic [13:0] cap_s = '0, cap_a = '0;

  function automatic logic [13:0] enc(input int h, input int m);
    logic [13:0] r;
    r[13:12] = 2'(h / 10);
    r[11:8]  = 4'(h % 10);
    r[7:4]   = 4'(m / 10);
    r[3:0]   = 4'(m % 10);
    return r;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_apply(input logic [3:0] ev);
    if (m_mode == 0) begin
      if (ev[0]) begin
        m_hh = cur_h; m_mm = cur_m; m_alarm_tgt = 0; m_mode = 1; m_idle = 0;
      end else if (ev[1]) begin
        m_hh = m_ah; m_mm = m_am; m_alarm_tgt = 1; m_mode = 1; m_idle = 0;
      end
    end else begin
      m_idle = 0;
      if (ev[3]) begin
        if (m_mode == 1) m_mode = 2;
        else begin
          m_mode = 0;
          if (m_alarm_tgt) begin m_la = 1; m_ah = m_hh; m_am = m_mm; end
          else m_ls = 1;
        end
      end else if (ev[2]) begin
        if (m_mode == 1) m_hh = (m_hh + 1) % 24;
        else             m_mm = (m_mm + 1) % 60;
      end
    end
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_hh = 0; m_mm = 0; m_ah = 0; m_am = 0; m_idle = 0;
    m_ls = 0; m_la = 0; m_alarm_tgt = 0;
  endfunction

  always @(negedge Ghadi) begin
    cmp("Editing", Editing, m_mode != 0);
    if (m_mode != 0) cmp("Edit_Field", Edit_Field, m_mode == 2);
    cmp("SET", {sht, sho, smt, smo}, enc(m_hh, m_mm));
    cmp("Load_Samay", Load_Samay, m_ls);
    cmp("Load_Alarm", Load_Alarm, m_la);
    if (Load_Samay === 1'b1) begin n_ls++; cap_s = {sht, sho, smt, smo}; end
    if (Load_Alarm === 1'b1) begin n_la++; cap_a = {sht, sho, smt, smo}; end
    m_ls = 0; m_la = 0;
    if (m_mode != 0) begin
      m_idle++;
      if (m_idle == TIMEOUT) m_mode = 0;
    end
  end

  task automatic set_cur(input int h, input int m);
    cur_h = h; cur_m = m;
    {cht, cho, cmt, cmo} = enc(h, m);
  endtask

  // FSM sees the debounced event at the 5th rising edge after the raw press.
  task automatic press(input logic [3:0] mask);
    @(negedge Ghadi); btn = mask;
    repeat (3) @(negedge Ghadi);
    btn = 4'b0;
    repeat (2) @(posedge Ghadi);
    #1 model_apply(mask);
    repeat (6) @(negedge Ghadi);
  endtask

  initial begin
    repeat (3) @(posedge Ghadi);
    #3 Reset = 1'b0;
    @(negedge Ghadi);
    cmp("lit_reset_set", {sht, sho, smt, smo}, 14'h0000);
    cmp("lit_reset_edit", Editing, 1'b0);

    set_cur(10, 19);
    press(B_S); press(B_U); press(B_N); press(B_U); press(B_U); press(B_N);
    cmp("lit_t1_nls", n_ls, 1);
    cmp("lit_t1_set", cap_s, 14'h1121);

    set_cur(23, 59);
    press(B_S); press(B_U); press(B_N); press(B_U); press(B_N);
    cmp("lit_t2_nls", n_ls, 2);
    cmp("lit_t2_set", cap_s, 14'h0000);

    press(B_A);
    repeat (10) press(B_U);
    press(B_N);
    repeat (20) press(B_U);
    press(B_N);
    cmp("lit_t3_nla", n_la, 1);
    cmp("lit_t3_set", cap_a, 14'h1020);
    press(B_A);
    cmp("lit_t3_reload", {sht, sho, smt, smo}, 14'h1020);
    press(B_N); press(B_N);
    cmp("lit_t3_nla2", n_la, 2);
    cmp("lit_t3_nls", n_ls, 2);

    set_cur(12, 34);
    press(B_S);
    repeat (TIMEOUT + 10) @(negedge Ghadi);
    cmp("lit_to_edit", Editing, 1'b0);
    cmp("lit_to_set", {sht, sho, smt, smo}, 14'h1234);
    cmp("lit_to_strobes", n_ls + n_la, 4);

    press(B_S);
    @(negedge Ghadi); btn = B_U;
    @(negedge Ghadi); btn = 4'b0;
    repeat (8) @(negedge Ghadi);
    cmp("lit_glitch_set", {sht, sho, smt, smo}, 14'h1234);

    press(B_U | B_N);
    cmp("lit_upnext_field", Edit_Field, 1'b1);
    cmp("lit_upnext_set", {sht, sho, smt, smo}, 14'h1234);

    @(posedge Ghadi); #3 Reset = 1'b1; model_reset();
    @(negedge Ghadi);
    cmp("lit_rst_edit", Editing, 1'b0);
    cmp("lit_rst_set", {sht, sho, smt, smo}, 14'h0000);
    cmp("lit_rst_strobe", {Load_Samay, Load_Alarm}, 2'b00);
    @(posedge Ghadi); #3 Reset = 1'b0;

    press(B_A);
    cmp("lit_rst_alarm", {sht, sho, smt, smo}, 14'h0000);
    cmp("lit_rst_alarm_edit", Editing, 1'b1);

    repeat (4) @(negedge Ghadi);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
